// File: rtl/fp_ack_parser.sv
// Byte-level parser for fingerprint-sensor acknowledge packets received over UART.
// Validates framing and checksum, extracts confirm/page_id/score and drives the search flags.
module fp_ack_parser #(
    parameter logic [31:0] DEV_ADDR     = 32'hFFFF_FFFF,
    parameter logic [15:0] MAX_LEN      = 16'd32,
    parameter logic [23:0] BYTE_TIMEOUT = 24'd2_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        flag_clr,
    output logic [1:0]  flag,
    output logic [7:0]  confirm,
    output logic [15:0] page_id,
    output logic [15:0] score,
    output logic        ack_valid,
    output logic        pkt_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR1,
        S_ADDR,
        S_PID,
        S_LENH,
        S_LENL,
        S_PAY,
        S_CSH,
        S_CSL
    } state_t;

    state_t      state;
    logic [1:0]  addr_cnt;
    logic [23:0] addr_sr;
    logic [15:0] len_q;
    logic [15:0] pay_cnt;
    logic [15:0] sum_q;
    logic [7:0]  csh_q;
    logic [7:0]  cf_q;
    logic [15:0] pid_q;
    logic [15:0] sc_q;
    logic [23:0] timer;

    logic [15:0] len_w;
    logic [15:0] sum_next;
    logic [31:0] addr_w;
    logic        timeout;

    assign len_w    = {len_q[15:8], rx_data};
    assign sum_next = sum_q + {8'h00, rx_data};
    assign addr_w   = {addr_sr, rx_data};
    // Fires BYTE_TIMEOUT cycles after the last accepted byte; a byte arriving that cycle wins.
    assign timeout  = (state != S_IDLE) && !rx_valid && (timer >= BYTE_TIMEOUT - 24'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_cnt  <= 2'd0;
            addr_sr   <= 24'd0;
            len_q     <= 16'd0;
            pay_cnt   <= 16'd0;
            sum_q     <= 16'd0;
            csh_q     <= 8'd0;
            cf_q      <= 8'd0;
            pid_q     <= 16'd0;
            sc_q      <= 16'd0;
            timer     <= 24'd0;
            flag      <= 2'b00;
            confirm   <= 8'd0;
            page_id   <= 16'd0;
            score     <= 16'd0;
            ack_valid <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            ack_valid <= 1'b0;
            pkt_err   <= 1'b0;

            // A good packet below may override this clear in the same cycle.
            if (flag_clr) flag <= 2'b00;

            if (state == S_IDLE || rx_valid) timer <= 24'd0;
            else                             timer <= timer + 24'd1;

            if (timeout) begin
                pkt_err <= 1'b1;
                state   <= S_IDLE;
            end else if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == 8'hEF) state <= S_HDR1;
                    end
                    S_HDR1: begin
                        if (rx_data == 8'h01) begin
                            state    <= S_ADDR;
                            addr_cnt <= 2'd0;
                        end else if (rx_data != 8'hEF) begin
                            state <= S_IDLE;
                        end
                    end
                    S_ADDR: begin
                        addr_sr  <= addr_w[23:0];
                        addr_cnt <= addr_cnt + 2'd1;
                        if (addr_cnt == 2'd3) begin
                            if (addr_w == DEV_ADDR) begin
                                state <= S_PID;
                            end else begin
                                pkt_err <= 1'b1;
                                state   <= S_IDLE;
                            end
                        end
                    end
                    S_PID: begin
                        if (rx_data == 8'h07) begin
                            sum_q <= {8'h00, rx_data};
                            state <= S_LENH;
                        end else begin
                            pkt_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    S_LENH: begin
                        len_q <= {rx_data, 8'h00};
                        sum_q <= sum_next;
                        state <= S_LENL;
                    end
                    S_LENL: begin
                        if (len_w < 16'd3 || len_w > MAX_LEN) begin
                            pkt_err <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            len_q   <= len_w;
                            sum_q   <= sum_next;
                            pay_cnt <= 16'd0;
                            state   <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        sum_q   <= sum_next;
                        pay_cnt <= pay_cnt + 16'd1;
                        case (pay_cnt)
                            16'd0:   cf_q        <= rx_data;
                            16'd1:   pid_q[15:8] <= rx_data;
                            16'd2:   pid_q[7:0]  <= rx_data;
                            16'd3:   sc_q[15:8]  <= rx_data;
                            16'd4:   sc_q[7:0]   <= rx_data;
                            default: ;
                        endcase
                        // Payload holds LEN-2 bytes, so the last index is LEN-3.
                        if (pay_cnt == len_q - 16'd3) state <= S_CSH;
                    end
                    S_CSH: begin
                        csh_q <= rx_data;
                        state <= S_CSL;
                    end
                    S_CSL: begin
                        state <= S_IDLE;
                        if ({csh_q, rx_data} == sum_q) begin
                            ack_valid <= 1'b1;
                            confirm   <= cf_q;
                            if (len_q >= 16'd7) begin
                                page_id <= pid_q;
                                score   <= sc_q;
                            end
                            if (cf_q == 8'h00)      flag <= 2'b01;
                            else if (cf_q == 8'h09) flag <= 2'b10;
                        end else begin
                            pkt_err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_ack_parser.sv
// Self-checking bench for fp_ack_parser: directed vector table, hand-written corner
// sequences and randomized packets checked against a packet-level reference model.
module tb_fp_ack_parser;

    localparam logic [31:0] DEV_ADDR = 32'hFFFF_FFFF;
    localparam logic [15:0] MAX_LEN  = 16'd32;
    localparam int          TOUT     = 200;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [127:0] bytes;
        int           n;
        int           exp_evt;
        logic [1:0]   exp_flag;
        logic [7:0]   exp_conf;
        logic [15:0]  exp_page;
        logic [15:0]  exp_score;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        flag_clr = 1'b0;
    logic [1:0]  flag;
    logic [7:0]  confirm;
    logic [15:0] page_id;
    logic [15:0] score;
    logic        ack_valid;
    logic        pkt_err;

    int tests = 0;
    int fails = 0;

    logic [1:0]  m_flag;
    logic [7:0]  m_conf;
    logic [15:0] m_page;
    logic [15:0] m_score;

    fp_ack_parser #(
        .DEV_ADDR    (DEV_ADDR),
        .MAX_LEN     (MAX_LEN),
        .BYTE_TIMEOUT(24'(TOUT))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .flag_clr (flag_clr),
        .flag     (flag),
        .confirm  (confirm),
        .page_id  (page_id),
        .score    (score),
        .ack_valid(ack_valid),
        .pkt_err  (pkt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [1:0] f, input logic [7:0] c,
                            input logic [15:0] p, input logic [15:0] s);
        chk({nm, ".flag"},    32'(flag),    32'(f));
        chk({nm, ".confirm"}, 32'(confirm), 32'(c));
        chk({nm, ".page_id"}, 32'(page_id), 32'(p));
        chk({nm, ".score"},   32'(score),   32'(s));
    endtask

    // Sends p[0..last]; evt: 0 = no pulse expected, 1 = ack on last byte, 2 = error on last byte.
    task automatic run_pkt(input byte_q_t p, input int last, input int evt, input int max_gap,
                           input bit clr_last, input string nm);
        for (int i = 0; i <= last; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk) #1;
            rx_data  = p[i];
            rx_valid = 1'b1;
            flag_clr = clr_last && (i == last);
            @(posedge clk) #1;
            rx_valid = 1'b0;
            flag_clr = 1'b0;
            chk($sformatf("%s.ack[%0d]", nm, i), 32'(ack_valid), 32'(i == last && evt == 1));
            chk($sformatf("%s.err[%0d]", nm, i), 32'(pkt_err),   32'(i == last && evt == 2));
        end
    endtask

    // Packet-level reference: decides where and how a well-framed packet ends.
    task automatic analyze(input byte_q_t p, output int last, output bit good);
        logic [15:0] len;
        logic [15:0] sum;
        good = 1'b0;
        if ({p[2], p[3], p[4], p[5]} != DEV_ADDR) begin last = 5; return; end
        if (p[6] != 8'h07) begin last = 6; return; end
        len = {p[7], p[8]};
        if (len < 16'd3 || len > MAX_LEN) begin last = 8; return; end
        sum = 16'd0;
        for (int i = 6; i <= 8 + int'(len) - 2; i++) sum = sum + 16'(p[i]);
        last = 8 + int'(len);
        good = ({p[last - 1], p[last]} == sum);
    endtask

    function automatic byte_q_t vec_bytes(input vec_t v);
        byte_q_t q;
        for (int i = 0; i < v.n; i++) q.push_back(v.bytes[127 - 8*i -: 8]);
        return q;
    endfunction

    function automatic byte_q_t gen_pkt(input int kind);
        byte_q_t q;
        int          len;
        logic [15:0] sum;
        logic [7:0]  b;
        int          r;
        q = '{8'hEF, 8'h01, DEV_ADDR[31:24], DEV_ADDR[23:16], DEV_ADDR[15:8], DEV_ADDR[7:0], 8'h07};
        len = $urandom_range(3, int'(MAX_LEN));
        if (kind == 4) begin
            len = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2)
                                              : int'(MAX_LEN) + 1 + $urandom_range(0, 300);
        end
        q.push_back(8'(len >> 8));
        q.push_back(8'(len));
        sum = 16'h0007 + 16'(len >> 8) + 16'(len & 255);
        if (kind != 4) begin
            for (int i = 0; i < len - 2; i++) begin
                b = 8'($urandom);
                if (i == 0) begin
                    r = $urandom_range(0, 2);
                    b = (r == 0) ? 8'h00 : (r == 1) ? 8'h09 : b;
                end
                q.push_back(b);
                sum = sum + 16'(b);
            end
            q.push_back(sum[15:8]);
            q.push_back(sum[7:0]);
        end
        if (kind == 2) q[2 + $urandom_range(0, 3)] ^= 8'($urandom_range(1, 255));
        if (kind == 3) begin
            q[6] = 8'($urandom_range(0, 255));
            if (q[6] == 8'h07) q[6] = 8'h08;
        end
        if (kind == 5) q[q.size() - 1] ^= 8'($urandom_range(1, 255));
        return q;
    endfunction

    vec_t    tv[9];
    byte_q_t q;
    byte_q_t t1;

    initial begin
        tv[0] = '{128'hEF01FFFFFFFF07000700000500640077, 16, 1, 2'b01, 8'h00, 16'h0005, 16'h0064};
        tv[1] = '{128'hEF01FFFFFFFF07000309001300000000, 12, 1, 2'b10, 8'h09, 16'h0005, 16'h0064};
        tv[2] = '{128'hEF01FFFFFFFF07000700000500640078, 16, 2, 2'b10, 8'h09, 16'h0005, 16'h0064};
        tv[3] = '{128'hEF01FFFFFFFF07004000000000000000,  9, 2, 2'b10, 8'h09, 16'h0005, 16'h0064};
        tv[4] = '{128'hEF01FFFFFFFF07000700000500640077, 16, 1, 2'b01, 8'h00, 16'h0005, 16'h0064};
        tv[5] = '{128'hEF01FFFFFFFF08000000000000000000,  7, 2, 2'b01, 8'h00, 16'h0005, 16'h0064};
        tv[6] = '{128'hEF01FFFEFFFF00000000000000000000,  6, 2, 2'b01, 8'h00, 16'h0005, 16'h0064};
        tv[7] = '{128'hEF01FFFFFFFF07000701002A0100003A, 16, 1, 2'b01, 8'h01, 16'h002A, 16'h0100};
        tv[8] = '{128'hEF01FFFFFFFF07000200000000000000,  9, 2, 2'b01, 8'h01, 16'h002A, 16'h0100};
        t1 = vec_bytes(tv[0]);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_outs("reset", 2'b00, 8'h00, 16'h0000, 16'h0000);
        chk("reset.ack", 32'(ack_valid), 32'd0);
        chk("reset.err", 32'(pkt_err),   32'd0);

        // Directed vectors, sent back-to-back with no idle gap.
        for (int v = 0; v < 9; v++) begin
            q = vec_bytes(tv[v]);
            run_pkt(q, tv[v].n - 1, tv[v].exp_evt, 0, 1'b0, $sformatf("vec%0d", v));
            chk_outs($sformatf("vec%0d", v), tv[v].exp_flag, tv[v].exp_conf,
                     tv[v].exp_page, tv[v].exp_score);
        end

        // Stall after 6 bytes: exactly one error, TOUT cycles after the last byte.
        begin
            int cnt;
            int first;
            cnt = 0;
            first = -1;
            run_pkt(t1, 5, 0, 0, 1'b0, "tout_pre");
            for (int k = 1; k <= TOUT + 20; k++) begin
                @(posedge clk) #1;
                if (pkt_err) begin
                    cnt++;
                    if (first < 0) first = k;
                end
            end
            chk("tout.count", 32'(cnt), 32'd1);
            chk("tout.cycle", 32'(first), 32'(TOUT));
            chk_outs("tout", 2'b01, 8'h01, 16'h002A, 16'h0100);
            run_pkt(t1, 15, 1, 0, 1'b0, "tout_post");
            chk_outs("tout_post", 2'b01, 8'h00, 16'h0005, 16'h0064);
        end

        // Noise ahead of a packet, with flag_clr landing on the final byte.
        q = vec_bytes(tv[1]);
        run_pkt(q, 11, 1, 0, 1'b0, "pre_noise");
        chk_outs("pre_noise", 2'b10, 8'h09, 16'h0005, 16'h0064);
        q = '{8'h12, 8'hEF};
        run_pkt(q, 1, 0, 0, 1'b0, "noise");
        run_pkt(t1, 15, 1, 0, 1'b1, "noise_pkt");
        chk_outs("noise_pkt", 2'b01, 8'h00, 16'h0005, 16'h0064);

        flag_clr = 1'b1;
        @(posedge clk) #1;
        flag_clr = 1'b0;
        chk("flag_clr", 32'(flag), 32'd0);

        // Reset in the middle of a packet.
        run_pkt(t1, 15, 1, 0, 1'b0, "pre_rst");
        run_pkt(t1, 7, 0, 0, 1'b0, "mid_rst");
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        chk_outs("mid_rst", 2'b00, 8'h00, 16'h0000, 16'h0000);
        chk("mid_rst.ack", 32'(ack_valid), 32'd0);
        chk("mid_rst.err", 32'(pkt_err),   32'd0);
        run_pkt(t1, 15, 1, 0, 1'b0, "post_rst");
        chk_outs("post_rst", 2'b01, 8'h00, 16'h0005, 16'h0064);

        // Randomized packets against the reference model.
        m_flag = 2'b01; m_conf = 8'h00; m_page = 16'h0005; m_score = 16'h0064;
        for (int n = 0; n < 150; n++) begin
            int  kind;
            int  last;
            bit  good;
            bit  clr;
            kind = $urandom_range(0, 5);
            clr  = ($urandom_range(0, 7) == 0);
            q = gen_pkt(kind);
            analyze(q, last, good);
            if (clr) m_flag = 2'b00;
            if (good) begin
                m_conf = q[9];
                if ({q[7], q[8]} >= 16'd7) begin
                    m_page  = {q[10], q[11]};
                    m_score = {q[12], q[13]};
                end
                if (q[9] == 8'h00)      m_flag = 2'b01;
                else if (q[9] == 8'h09) m_flag = 2'b10;
            end
            run_pkt(q, last, good ? 1 : 2, 3, clr, $sformatf("rnd%0d", n));
            chk_outs($sformatf("rnd%0d", n), m_flag, m_conf, m_page, m_score);
            if ($urandom_range(0, 9) == 0) begin
                flag_clr = 1'b1;
                @(posedge clk) #1;
                flag_clr = 1'b0;
                m_flag = 2'b00;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
